// File: rtl/fault_mon_pkg.sv
// Shared types for the multi-channel fault monitor: channel states, fault cause codes
// and a helper that turns violation flags into a cause code.
package fault_mon_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        WARNING  = 2'd1,
        FAULT    = 2'd2,
        SHUTDOWN = 2'd3
    } ch_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_HI   = 2'b01,
        CAUSE_LO   = 2'b10
    } cause_e;

    // High violation wins when both limits are crossed (only possible with thr_lo > thr_hi)
    function automatic cause_e pick_cause(input logic hi_viol, input logic lo_viol);
        if (hi_viol) begin
            return CAUSE_HI;
        end else if (lo_viol) begin
            return CAUSE_LO;
        end
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/fault_monitor_mc_if.sv
// Sample/threshold bus feeding the fault monitor; the driver side uses master, the monitor slave.
interface fault_monitor_mc_if #(
    parameter int NCH = 4,
    parameter int W   = 16
);
    logic [NCH-1:0]   sample_valid;
    logic [NCH*W-1:0] sample;
    logic [NCH*W-1:0] thr_hi;
    logic [NCH*W-1:0] thr_lo;
    logic [NCH-1:0]   ch_en;

    modport master (output sample_valid, sample, thr_hi, thr_lo, ch_en);
    modport slave  (input  sample_valid, sample, thr_hi, thr_lo, ch_en);
endinterface

// File: rtl/fault_chan.sv
// One monitored channel: limit comparators, debounce counter, ok_last flag and the
// NORMAL/WARNING/FAULT/SHUTDOWN machine. Log-related ports exist only with FAULT_LOG_EN.
module fault_chan
    import fault_mon_pkg::*;
#(
    parameter int W        = 16,
    parameter int WARN_CNT = 3,
    parameter int CW       = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         valid,
    input  logic [W-1:0] sample,
    input  logic [W-1:0] thr_hi,
    input  logic [W-1:0] thr_lo,
    input  logic         en,
    input  logic         clr,
`ifdef FAULT_LOG_EN
    output logic         fault_entry,
    output cause_e       entry_cause,
    output ch_state_e    state_next,
`endif
    output ch_state_e    state
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WARN_CNT - 1);

    ch_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ok_last_q, ok_last_d;
    logic          hi_viol, lo_viol, abn;

    assign hi_viol = sample > thr_hi;
    assign lo_viol = sample < thr_lo;
    assign abn     = hi_viol | lo_viol;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ok_last_d = valid ? !abn : ok_last_q;

        case (state_q)
            NORMAL: begin
                if (valid && abn) begin
                    state_d = WARNING;
                    cnt_d   = CW'(1);
                end
            end
            WARNING: begin
                if (valid) begin
                    if (!abn) begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = FAULT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FAULT: begin
                state_d = SHUTDOWN;
            end
            SHUTDOWN: begin
                // Release needs the previous valid sample to be back in range
                if (clr && ok_last_q) begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = NORMAL;
                cnt_d   = '0;
            end
        endcase

        if (!en) begin
            state_d = NORMAL;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= NORMAL;
            cnt_q     <= '0;
            ok_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ok_last_q <= ok_last_d;
        end
    end

    assign state = state_q;

`ifdef FAULT_LOG_EN
    assign fault_entry = (state_d == FAULT);
    assign entry_cause = pick_cause(hi_viol, lo_viol);
    assign state_next  = state_d;
`endif

endmodule

// File: rtl/fault_monitor_mc.sv
// Multi-channel fault monitor top: per-channel FSMs, registered global shutdown and,
// when FAULT_LOG_EN is defined, a first-fault log (first_ch/first_cause).
module fault_monitor_mc
    import fault_mon_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int W        = 16,
    parameter int WARN_CNT = 3,
    parameter int CW       = 8
) (
    input  logic                clk,
    input  logic                rstn,
    fault_monitor_mc_if.slave   smp,
    input  logic                clr,
    output logic [NCH-1:0]      warning,
    output logic [NCH-1:0]      fault,
    output logic                shutdown,
    output logic [3:0]          first_ch,
    output logic [1:0]          first_cause
);

    ch_state_e      state [NCH];
    logic [NCH-1:0] shut_vec;
    logic           shutdown_q, shutdown_d;

`ifdef FAULT_LOG_EN
    logic           entry [NCH];
    cause_e         entry_cause [NCH];
    ch_state_e      state_next [NCH];
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        fault_chan #(
            .W        (W),
            .WARN_CNT (WARN_CNT),
            .CW       (CW)
        ) u_chan (
            .clk         (clk),
            .rstn        (rstn),
            .valid       (smp.sample_valid[i]),
            .sample      (smp.sample[i*W +: W]),
            .thr_hi      (smp.thr_hi[i*W +: W]),
            .thr_lo      (smp.thr_lo[i*W +: W]),
            .en          (smp.ch_en[i]),
            .clr         (clr),
`ifdef FAULT_LOG_EN
            .fault_entry (entry[i]),
            .entry_cause (entry_cause[i]),
            .state_next  (state_next[i]),
`endif
            .state       (state[i])
        );

        assign warning[i]  = (state[i] == WARNING);
        assign fault[i]    = (state[i] == FAULT) || (state[i] == SHUTDOWN);
        assign shut_vec[i] = (state[i] == SHUTDOWN);
    end

    // Extra register stage places shutdown two cycles after the matching fault edge
    assign shutdown_d = |shut_vec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shutdown_q <= 1'b0;
        end else begin
            shutdown_q <= shutdown_d;
        end
    end

    assign shutdown = shutdown_q;

`ifdef FAULT_LOG_EN
    logic [3:0] first_ch_q, first_ch_d;
    cause_e     first_cause_q, first_cause_d;
    logic       busy_next;

    always_comb begin
        first_ch_d    = first_ch_q;
        first_cause_d = first_cause_q;
        busy_next     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (state_next[i] == FAULT || state_next[i] == SHUTDOWN) begin
                busy_next = 1'b1;
            end
        end

        if (clr && !busy_next) begin
            first_ch_d    = '0;
            first_cause_d = CAUSE_NONE;
        end else if (first_cause_q == CAUSE_NONE) begin
            // Walk downwards so the lowest-index entering channel is the one kept
            for (int i = NCH - 1; i >= 0; i--) begin
                if (entry[i]) begin
                    first_ch_d    = 4'(i);
                    first_cause_d = entry_cause[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first_ch_q    <= '0;
            first_cause_q <= CAUSE_NONE;
        end else begin
            first_ch_q    <= first_ch_d;
            first_cause_q <= first_cause_d;
        end
    end

    assign first_ch    = first_ch_q;
    assign first_cause = first_cause_q;
`else
    assign first_ch    = '0;
    assign first_cause = CAUSE_NONE;
`endif

endmodule
